// File: rtl/retire_stage.sv
`default_nettype none
// ============================================================================
// Module   : retire_stage
// Brief    : In-order commit stage behind the ROB. Decides combinationally how
//            many of the N oldest entries retire, then registers arch-map
//            commits and free-list returns. Handles mispredict flush and halt.
//            Optional macro RETIRE_COUNTER_EN builds the 64-bit retire counter.
// Revision : 1.0 - initial release
// ============================================================================
module retire_stage #(
   parameter int N           = 3,
   parameter int ARCH_BITS   = 5,
   parameter int PRN_BITS    = 6,
   parameter int SCALAR_BITS = $clog2(N + 1)
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [SCALAR_BITS-1:0] rob_outputs_valid,
   input  logic [N-1:0]           rob_complete,
   input  logic [N*ARCH_BITS-1:0] rob_dest_arch,
   input  logic [N*PRN_BITS-1:0]  rob_t,
   input  logic [N*PRN_BITS-1:0]  rob_told,
   input  logic [N-1:0]           rob_mispredict,
   input  logic [N-1:0]           rob_halt,
   output logic [SCALAR_BITS-1:0] num_retiring,
   output logic [N-1:0]           commit_valid,
   output logic [N*ARCH_BITS-1:0] commit_arch,
   output logic [N*PRN_BITS-1:0]  commit_phys,
   output logic [N-1:0]           free_valid,
   output logic [N*PRN_BITS-1:0]  free_phys,
   output logic                   flush,
   output logic                   halted,
   output logic [63:0]            retired_count
);

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_FLUSH  = 2'd1,
      ST_HALTED = 2'd2
   } state_t;

   state_t                   r_state;
   state_t                   w_next_state;
   logic [N-1:0]             w_retire;
   logic [N-1:0]             w_has_dest;
   logic [SCALAR_BITS-1:0]   w_count;
   logic [SCALAR_BITS-1:0]   w_limit;
   logic                     w_stop;

   logic [N-1:0]             r_commit_valid;
   logic [N*ARCH_BITS-1:0]   r_commit_arch;
   logic [N*PRN_BITS-1:0]    r_commit_phys;
   logic [N-1:0]             r_free_valid;
   logic [N*PRN_BITS-1:0]    r_free_phys;

   // Retire scan: contiguous from slot 0, stops at the first non-eligible
   // slot or just after a retiring halt/mispredict. Halt wins over mispredict.
   always_comb begin
      w_limit      = (rob_outputs_valid > SCALAR_BITS'(N)) ? SCALAR_BITS'(N) : rob_outputs_valid;
      w_retire     = '0;
      w_count      = '0;
      w_next_state = r_state;
      w_stop       = !reset || (r_state != ST_RUN);
      for (int i = 0; i < N; i++) begin
         if (!w_stop && (SCALAR_BITS'(i) < w_limit) && rob_complete[i]) begin
            w_retire[i] = 1'b1;
            w_count     = w_count + SCALAR_BITS'(1);
            if (rob_halt[i]) begin
               w_next_state = ST_HALTED;
               w_stop       = 1'b1;
            end else if (rob_mispredict[i]) begin
               w_next_state = ST_FLUSH;
               w_stop       = 1'b1;
            end
         end else begin
            w_stop = 1'b1;
         end
      end
      if (r_state == ST_FLUSH) begin
         w_next_state = ST_RUN;
      end
   end

   always_comb begin
      w_has_dest = '0;
      for (int i = 0; i < N; i++) begin
         w_has_dest[i] = (rob_dest_arch[i*ARCH_BITS +: ARCH_BITS] != '0);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state        <= ST_RUN;
         r_commit_valid <= '0;
         r_commit_arch  <= '0;
         r_commit_phys  <= '0;
         r_free_valid   <= '0;
         r_free_phys    <= '0;
      end else begin
         r_state        <= w_next_state;
         r_commit_valid <= w_retire & w_has_dest;
         r_free_valid   <= w_retire & w_has_dest;
         // Data lanes are only meaningful where the matching enable is set.
         r_commit_arch  <= rob_dest_arch;
         r_commit_phys  <= rob_t;
         r_free_phys    <= rob_told;
      end
   end

`ifdef RETIRE_COUNTER_EN
   logic [63:0] r_retired_count;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_retired_count <= 64'd0;
      end else begin
         r_retired_count <= r_retired_count + 64'(w_count);
      end
   end

   assign retired_count = r_retired_count;
`else
   assign retired_count = 64'd0;
`endif

   assign num_retiring = w_count;
   assign commit_valid = r_commit_valid;
   assign commit_arch  = r_commit_arch;
   assign commit_phys  = r_commit_phys;
   assign free_valid   = r_free_valid;
   assign free_phys    = r_free_phys;
   assign flush        = (r_state == ST_FLUSH);
   assign halted       = (r_state == ST_HALTED);

endmodule
`default_nettype wire

// File: doc/retire_stage.md
# retire_stage

In-order commit stage placed directly downstream of the reorder buffer. Each cycle it examines the up-to-N oldest ROB entries, decides combinationally how many retire, and returns that count to the ROB so the entries free in the same cycle. One cycle later it drives registered architectural-map commits and free-list returns. A three-state FSM handles mispredict flushes and program halt.

## Interface
- N, 3, superscalar width (maximum retires per cycle)
- ARCH_BITS, 5, architectural register index width
- PRN_BITS, 6, physical register index width
- SCALAR_BITS, $clog2(N+1), width of count fields
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- rob_outputs_valid  in  SCALAR_BITS  number of valid oldest ROB entries presented (slot 0 = oldest)
- rob_complete  in  N  per-slot execution-complete flag
- rob_dest_arch  in  N*ARCH_BITS  per-slot destination architectural register (0 = no destination)
- rob_t  in  N*PRN_BITS  per-slot newly allocated physical register
- rob_told  in  N*PRN_BITS  per-slot previous mapping of the destination
- rob_mispredict  in  N  per-slot resolved-mispredicted-branch flag
- rob_halt  in  N  per-slot halt instruction flag
- num_retiring  out  SCALAR_BITS  combinational retire count to the ROB
- commit_valid  out  N  registered per-slot arch-map write enable
- commit_arch  out  N*ARCH_BITS  registered arch-map index
- commit_phys  out  N*PRN_BITS  registered arch-map value (T)
- free_valid  out  N  registered per-slot free-list return enable
- free_phys  out  N*PRN_BITS  registered register returned to the free list (Told)
- flush  out  1  registered one-cycle pipeline flush pulse
- halted  out  1  registered; high once a halt has retired
- retired_count  out  64  registered running retire total

## Operation
- FSM states: RUN, FLUSH, HALTED. Reset state: RUN.
- Retire eligibility in RUN:
  - Slot i retires only if i < min(rob_outputs_valid, N), rob_complete[i]=1, and every slot below i retires.
  - The scan stops after the first retiring slot with rob_mispredict=1 or rob_halt=1; that slot retires and later slots do not.
- num_retiring is the count of retiring slots. It is 0 in FLUSH and HALTED.
- Commit and free behaviour for retiring slot i with rob_dest_arch≠0, registered at the next edge:
  - commit_valid[i]=1, commit_arch[i]=dest, commit_phys[i]=T.
  - free_valid[i]=1, free_phys[i]=Told.
  - Slots that do not retire, or have dest 0, produce enables of 0. Data fields for those slots are don't-care.
- Transitions:
  - A retiring halt moves RUN to HALTED. HALTED is sticky until reset.
  - A retiring mispredict without halt moves RUN to FLUSH.
  - FLUSH returns to RUN after one cycle.
  - If the same slot has both halt and mispredict set, halt takes precedence and no flush is issued.
- flush is 1 exactly during the FLUSH-state cycle. halted is 1 in HALTED.

## Timing
- num_retiring is combinational from the inputs and state, with zero-cycle latency. The ROB clears the entries at the same edge.
- commit_*, free_*, flush, halted and retired_count update at the edge following the retire decision, giving one cycle of latency.
- A mispredict retiring at cycle t produces:
  - flush=1 at t+1, with num_retiring forced to 0 at t+1;
  - retirement resuming at t+2.
- Reset values while reset=0:
  - state RUN;
  - commit_valid, free_valid, flush and halted all 0;
  - commit/free data 0;
  - retired_count 0.
- num_retiring during reset is 0.
- Assertion of reset mid-FLUSH or in HALTED returns the block to RUN immediately and asynchronously. Any pending registered commits are discarded.

## Configuration
- RETIRE_COUNTER_EN defined:
  - retired_count increments by num_retiring at every edge.
  - It wraps modulo 2^64.
- RETIRE_COUNTER_EN undefined:
  - The counter register is not built.
  - retired_count is constant 0.
  - All other behaviour is identical.

## Test plan
- All-complete, no specials: N=3, rob_outputs_valid=3, complete=3'b111, dests 1/2/3 → num_retiring=3. Next cycle commit_valid=3'b111 and free_valid=3'b111 with matching T/Told. retired_count +3.
- Hole in completion: valid=3, complete=3'b101 → num_retiring=1. Next cycle only slot 0 has commit/free enables set.
- Mispredict: slot 1 has mispredict, all three slots complete → num_retiring=2. At t+1, flush=1 and num_retiring=0 even with eligible inputs. At t+2, retirement resumes.
- Halt: slot 0 has halt, all complete → num_retiring=1. At t+1, halted=1. Thereafter num_retiring=0 indefinitely with valid inputs.
- Destination register 0 and clamp: slot 0 dest=0, rob_outputs_valid forced to 3 with N=3 → slot 0 retires with commit_valid[0]=0 and free_valid[0]=0.
- Async reset: drive reset=0 during FLUSH and during HALTED → all outputs return to reset values without a clock edge. After release, normal retire resumes in RUN.
